hamming_classifier: RTL and testbench

Associative-search stage that sits directly downstream of the class-memory trainer. It takes one encoded query hypervector and the two stored class hypervectors (non-seizure, seizure). It computes both Hamming distances sequentially, PAR_BITS bits per cycle, and emits the label of the nearer class. It uses the same en/done handshake as the trainer, so the top level can drive either block from one controller.

---
 rtl/hamming_classifier.sv | 213 +++++++++++++++++++++
 tb/tb_hamming_classifier.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_classifier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hamming_classifier
//
// Associative-search stage for the hypervector seizure detector. On a start
// request it latches one query hypervector and the two class hypervectors. It
// then accumulates both Hamming distances PAR_BITS bits per cycle, LSB chunk
// first, and publishes the label of the nearer class together with both
// distances. It uses the same en/done handshake as the class-memory trainer.
//
// Parameters
//   DIMENSIONS      hypervector width in bits
//   PAR_BITS        bits compared per class per cycle (1..DIMENSIONS)
//
// Ports
//   clk             clock, rising edge
//   nrst            asynchronous active-low reset
//   en              start request, sampled only while idle
//   hv_query        encoded query hypervector
//   hv_nonseizure   class hypervector for label 0
//   hv_seizure      class hypervector for label 1
//   done            high while idle; results valid
//   label           0 = non-seizure, 1 = seizure (tie resolves to 0)
//   dist_nonseizure Hamming distance query vs hv_nonseizure
//   dist_seizure    Hamming distance query vs hv_seizure
//
// Timing: start accepted on edge E0, chunks processed on E1..E_NUM_CHUNKS,
// results and done appear on E_(NUM_CHUNKS+1). All outputs are registered.
// ---------------------------------------------------------------------------
module hamming_classifier #(
    parameter int unsigned DIMENSIONS = 10000,
    parameter int unsigned PAR_BITS   = 10
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                en,
    input  logic [DIMENSIONS-1:0]               hv_query,
    input  logic [DIMENSIONS-1:0]               hv_nonseizure,
    input  logic [DIMENSIONS-1:0]               hv_seizure,
    output logic                                done,
    output logic                                label,
    output logic [$clog2(DIMENSIONS+1)-1:0]     dist_nonseizure,
    output logic [$clog2(DIMENSIONS+1)-1:0]     dist_seizure
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int unsigned NUM_CHUNKS = (DIMENSIONS + PAR_BITS - 1) / PAR_BITS;
    localparam int unsigned DIST_W     = $clog2(DIMENSIONS + 1);
    localparam int unsigned PAD_W      = NUM_CHUNKS * PAR_BITS;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    // Number of real (non-padding) bits in the final chunk.
    localparam int unsigned LAST_VALID = DIMENSIONS - (NUM_CHUNKS - 1) * PAR_BITS;

    localparam logic [CNT_W-1:0]    LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [PAR_BITS-1:0] FULL_MASK  = {PAR_BITS{1'b1}};
    localparam logic [PAR_BITS-1:0] TAIL_MASK  = FULL_MASK >> (PAR_BITS - LAST_VALID);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [DIST_W-1:0]   acc_ns_q,  acc_ns_d;
    logic [DIST_W-1:0]   acc_s_q,   acc_s_d;

    // Latched operands, shifted right one chunk per ACCUM cycle so the chunk
    // under test is always in the low PAR_BITS bits.
    logic [PAD_W-1:0]    q_sh_q,    q_sh_d;
    logic [PAD_W-1:0]    ns_sh_q,   ns_sh_d;
    logic [PAD_W-1:0]    s_sh_q,    s_sh_d;

    logic                done_q,    done_d;
    logic                label_q,   label_d;
    logic [DIST_W-1:0]   dist_ns_q, dist_ns_d;
    logic [DIST_W-1:0]   dist_s_q,  dist_s_d;

    // Current-chunk datapath
    logic [PAR_BITS-1:0] chunk_mask_c;
    logic [PAR_BITS-1:0] diff_ns_c;
    logic [PAR_BITS-1:0] diff_s_c;
    logic [DIST_W-1:0]   pop_ns_c;
    logic [DIST_W-1:0]   pop_s_c;

    // Population count of one chunk, sized to the distance width.
    function automatic logic [DIST_W-1:0] popcount(input logic [PAR_BITS-1:0] v);
        logic [DIST_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < PAR_BITS; i++) begin
            n = n + DIST_W'(v[i]);
        end
        return n;
    endfunction

    // Mask out the padding bits of the final chunk. The shift registers are
    // zero-padded as well, so padding never contributes to a distance.
    always_comb begin
        chunk_mask_c = FULL_MASK;
        if (cnt_q == LAST_CHUNK) begin
            chunk_mask_c = TAIL_MASK;
        end
    end

    // Per-chunk mismatch vectors and their weights
    always_comb begin
        diff_ns_c = (q_sh_q[PAR_BITS-1:0] ^ ns_sh_q[PAR_BITS-1:0]) & chunk_mask_c;
        diff_s_c  = (q_sh_q[PAR_BITS-1:0] ^ s_sh_q[PAR_BITS-1:0])  & chunk_mask_c;
        pop_ns_c  = popcount(diff_ns_c);
        pop_s_c   = popcount(diff_s_c);
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_ns_d  = acc_ns_q;
        acc_s_d   = acc_s_q;
        q_sh_d    = q_sh_q;
        ns_sh_d   = ns_sh_q;
        s_sh_d    = s_sh_q;
        done_d    = done_q;
        label_d   = label_q;
        dist_ns_d = dist_ns_q;
        dist_s_d  = dist_s_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    q_sh_d   = PAD_W'(hv_query);
                    ns_sh_d  = PAD_W'(hv_nonseizure);
                    s_sh_d   = PAD_W'(hv_seizure);
                    cnt_d    = '0;
                    acc_ns_d = '0;
                    acc_s_d  = '0;
                    done_d   = 1'b0;
                    state_d  = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                acc_ns_d = acc_ns_q + pop_ns_c;
                acc_s_d  = acc_s_q + pop_s_c;
                q_sh_d   = q_sh_q >> PAR_BITS;
                ns_sh_d  = ns_sh_q >> PAR_BITS;
                s_sh_d   = s_sh_q >> PAR_BITS;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CHUNK) begin
                    state_d = ST_RESULT;
                end
            end

            ST_RESULT: begin
                dist_ns_d = acc_ns_q;
                dist_s_d  = acc_s_q;
                // Strict compare: a tie resolves to non-seizure.
                label_d   = (acc_s_q < acc_ns_q);
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_ns_q  <= '0;
            acc_s_q   <= '0;
            q_sh_q    <= '0;
            ns_sh_q   <= '0;
            s_sh_q    <= '0;
            done_q    <= 1'b1;
            label_q   <= 1'b0;
            dist_ns_q <= '0;
            dist_s_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_ns_q  <= acc_ns_d;
            acc_s_q   <= acc_s_d;
            q_sh_q    <= q_sh_d;
            ns_sh_q   <= ns_sh_d;
            s_sh_q    <= s_sh_d;
            done_q    <= done_d;
            label_q   <= label_d;
            dist_ns_q <= dist_ns_d;
            dist_s_q  <= dist_s_d;
        end
    end

    assign done            = done_q;
    assign label           = label_q;
    assign dist_nonseizure = dist_ns_q;
    assign dist_seizure    = dist_s_q;

endmodule

// File: tb/tb_hamming_classifier.sv
`timescale 1ns/1ps
// Testbench for hamming_classifier: default-size instance driven from a
// vector table with a completion scoreboard, plus a small instance with a
// partial final chunk.
module tb_hamming_classifier;

    localparam int unsigned D   = 10000;
    localparam int unsigned P   = 10;
    localparam int unsigned NCH = 1000;
    localparam int unsigned DW  = 14;

    localparam int unsigned SD  = 25;
    localparam int unsigned SP  = 10;
    localparam int unsigned SDW = 5;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic [D-1:0]  hv_query, hv_nonseizure, hv_seizure;
    logic          done, label;
    logic [DW-1:0] dist_nonseizure, dist_seizure;

    logic           sm_en;
    logic [SD-1:0]  sm_q, sm_ns, sm_s;
    logic           sm_done, sm_label;
    logic [SDW-1:0] sm_dns, sm_ds;

    always #5 clk = ~clk;

    hamming_classifier #(.DIMENSIONS(D), .PAR_BITS(P)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .en              (en),
        .hv_query        (hv_query),
        .hv_nonseizure   (hv_nonseizure),
        .hv_seizure      (hv_seizure),
        .done            (done),
        .label           (label),
        .dist_nonseizure (dist_nonseizure),
        .dist_seizure    (dist_seizure)
    );

    hamming_classifier #(.DIMENSIONS(SD), .PAR_BITS(SP)) dut_small (
        .clk             (clk),
        .nrst            (nrst),
        .en              (sm_en),
        .hv_query        (sm_q),
        .hv_nonseizure   (sm_ns),
        .hv_seizure      (sm_s),
        .done            (sm_done),
        .label           (sm_label),
        .dist_nonseizure (sm_dns),
        .dist_seizure    (sm_ds)
    );

    typedef struct {
        logic [D-1:0] q;
        logic [D-1:0] ns;
        logic [D-1:0] s;
        int           e_ns;
        int           e_s;
        bit           e_l;
        string        nm;
    } vec_t;

    typedef struct {
        int    e_ns;
        int    e_s;
        bit    e_l;
        string nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] rand_vec();
        logic [D-1:0] v;
        for (int i = 0; i < int'(D); i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [D-1:0] flip(input logic [D-1:0] v, input int n, input int stride);
        logic [D-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r[(i * stride) % int'(D)] = ~r[(i * stride) % int'(D)];
        return r;
    endfunction

    task automatic add_vec(input logic [D-1:0] q, input logic [D-1:0] ns, input logic [D-1:0] s,
                           input int e_ns, input int e_s, input bit e_l, input string nm);
        vec_t v;
        v.q = q; v.ns = ns; v.s = s; v.e_ns = e_ns; v.e_s = e_s; v.e_l = e_l; v.nm = nm;
        tbl.push_back(v);
    endtask

    function automatic exp_t model(input logic [D-1:0] q, input logic [D-1:0] ns,
                                   input logic [D-1:0] s, input string nm);
        exp_t e;
        e.e_ns = $countones(q ^ ns);
        e.e_s  = $countones(q ^ s);
        e.e_l  = (e.e_s < e.e_ns);
        e.nm   = nm;
        return e;
    endfunction

    task automatic push_exp(input int e_ns, input int e_s, input bit e_l, input string nm);
        exp_t e;
        e.e_ns = e_ns; e.e_s = e_s; e.e_l = e_l; e.nm = nm;
        sb.push_back(e);
    endtask

    // Start one operation from an idle DUT with a single-cycle en pulse.
    task automatic start_op(input logic [D-1:0] q, input logic [D-1:0] ns, input logic [D-1:0] s,
                            input int e_ns, input int e_s, input bit e_l, input string nm);
        @(negedge clk);
        hv_query = q; hv_nonseizure = ns; hv_seizure = s; en = 1'b1;
        push_exp(e_ns, e_s, e_l, nm);
        @(negedge clk);
        en = 1'b0;
    endtask

    // Wait until the DUT is idle and every expected result has been seen.
    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(done === 1'b1 && sb.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, int'(n >= 5000), 0);
    endtask

    // Completion monitor: busy length, output hold while busy, scoreboard pop.
    initial begin : monitor
        logic          prev_done, hold_bad, l_label;
        logic [DW-1:0] l_ns, l_s;
        int            busy;
        exp_t          e;
        prev_done = 1'b1; hold_bad = 1'b0; busy = 0;
        l_label = 1'b0; l_ns = '0; l_s = '0;
        forever begin
            @(posedge clk);
            #1;
            if (nrst !== 1'b1) begin
                prev_done = 1'b1; hold_bad = 1'b0; busy = 0;
                l_label = 1'b0; l_ns = '0; l_s = '0;
            end else begin
                if (done !== 1'b1) begin
                    busy++;
                    if (label !== l_label || dist_nonseizure !== l_ns || dist_seizure !== l_s)
                        hold_bad = 1'b1;
                end else if (prev_done !== 1'b1) begin
                    n_done++;
                    chk("busy_cycles", busy, int'(NCH) + 1);
                    chk("outputs_held_while_busy", int'(hold_bad), 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, "_dist_ns"}, int'(dist_nonseizure), e.e_ns);
                        chk({e.nm, "_dist_s"},  int'(dist_seizure),    e.e_s);
                        chk({e.nm, "_label"},   int'(label),           int'(e.e_l));
                    end
                    l_label = label; l_ns = dist_nonseizure; l_s = dist_seizure;
                    busy = 0; hold_bad = 1'b0;
                end
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [D-1:0] q, ns, s, ones;
        exp_t e, e2;
        int n, base;

        nrst = 1'b0; en = 1'b0;
        hv_query = '0; hv_nonseizure = '0; hv_seizure = '0;
        sm_en = 1'b0; sm_q = '0; sm_ns = '0; sm_s = '0;
        ones = '1;

        repeat (3) @(negedge clk);
        chk("reset_done",     int'(done), 1);
        chk("reset_label",    int'(label), 0);
        chk("reset_dist_ns",  int'(dist_nonseizure), 0);
        chk("reset_dist_s",   int'(dist_seizure), 0);
        chk("reset_sm_done",  int'(sm_done), 1);
        chk("reset_sm_dists", int'(sm_dns) + int'(sm_ds), 0);
        nrst = 1'b1;

        // ---- vector table ----
        q = rand_vec();
        add_vec(q, q, ~q, 0, int'(D), 1'b0, "match");
        q = '0;
        for (int i = 0; i < int'(D); i += 2) q[i] = 1'b1;
        add_vec(q, '0, q, 5000, 0, 1'b1, "seizure_win");
        q = rand_vec(); ns = flip(q, 37, 211);
        add_vec(q, ns, ns, 37, 37, 1'b0, "tie");
        add_vec('0, '0, '0, 0, 0, 1'b0, "all_zero");
        add_vec(ones, '0, ones, int'(D), 0, 1'b1, "all_ones");
        q = rand_vec();
        add_vec(q, flip(q, 11, 97), flip(q, 10, 131), 11, 10, 1'b1, "near_s");
        q = rand_vec();
        add_vec(q, flip(q, 10, 97), flip(q, 11, 131), 10, 11, 1'b0, "near_ns");
        q = rand_vec();
        add_vec(q, flip(q, 2, int'(D) - 1), flip(q, 1, 0), 2, 1, 1'b1, "edge_bits");
        for (int k = 0; k < 2; k++) begin
            q = rand_vec(); ns = rand_vec(); s = rand_vec();
            e = model(q, ns, s, "random");
            add_vec(q, ns, s, e.e_ns, e.e_s, e.e_l, "random");
        end

        foreach (tbl[i]) begin
            start_op(tbl[i].q, tbl[i].ns, tbl[i].s, tbl[i].e_ns, tbl[i].e_s, tbl[i].e_l, tbl[i].nm);
            wait_idle(tbl[i].nm);
        end

        // ---- input isolation: inputs churn and en pulses while busy ----
        q = rand_vec(); ns = rand_vec(); s = rand_vec();
        e = model(q, ns, s, "isolation");
        base = n_done;
        start_op(q, ns, s, e.e_ns, e.e_s, e.e_l, e.nm);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            hv_query = ~hv_query;
            hv_nonseizure[$urandom_range(0, int'(D) - 32) +: 32] = $urandom;
            hv_seizure = {hv_seizure[0], hv_seizure[D-1:1]} ^ {{(D-32){1'b0}}, $urandom};
            en = 1'b1;
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        chk("iso_done", int'(done), 1);
        repeat (5) @(negedge clk);
        chk("iso_single_completion", n_done - base, 1);
        chk("iso_still_idle", int'(done), 1);

        // ---- back-to-back: en held high across the done edge ----
        q = rand_vec(); ns = rand_vec(); s = rand_vec();
        e = model(q, ns, s, "b2b_first");
        @(negedge clk);
        hv_query = q; hv_nonseizure = ns; hv_seizure = s; en = 1'b1;
        push_exp(e.e_ns, e.e_s, e.e_l, e.nm);
        @(negedge clk);
        q = rand_vec(); ns = rand_vec(); s = rand_vec();
        e2 = model(q, ns, s, "b2b_second");
        hv_query = q; hv_nonseizure = ns; hv_seizure = s;
        push_exp(e2.e_ns, e2.e_s, e2.e_l, e2.nm);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("b2b_restart_immediate", int'(done), 0);
        @(negedge clk);
        en = 1'b0;
        wait_idle("b2b");

        // ---- reset abort mid-operation, restart with en held through reset ----
        q = rand_vec(); ns = rand_vec(); s = rand_vec();
        e = model(q, ns, s, "aborted");
        @(negedge clk);
        hv_query = q; hv_nonseizure = ns; hv_seizure = s; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (499) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("abort_done",    int'(done), 1);
        chk("abort_label",   int'(label), 0);
        chk("abort_dist_ns", int'(dist_nonseizure), 0);
        chk("abort_dist_s",  int'(dist_seizure), 0);
        q = rand_vec(); ns = flip(q, 123, 53); s = rand_vec();
        hv_query = q; hv_nonseizure = ns; hv_seizure = s; en = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        push_exp(123, $countones(q ^ s), 1'b0, "post_reset");
        @(posedge clk);
        #1;
        chk("rst_release_start", int'(done), 0);
        @(negedge clk);
        en = 1'b0;
        wait_idle("post_reset");

        // ---- partial final chunk on the small instance ----
        @(negedge clk);
        sm_q = '1; sm_ns = '0; sm_s = '0; sm_en = 1'b1;
        @(posedge clk);
        #1;
        sm_en = 1'b0;
        n = 1;
        while (sm_done !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("small_busy_cycles", n - 1, 4);
        chk("small_dist_ns", int'(sm_dns), 25);
        chk("small_dist_s",  int'(sm_ds), 25);
        chk("small_label",   int'(sm_label), 0);

        @(negedge clk);
        sm_q = SD'($urandom); sm_ns = SD'($urandom); sm_s = SD'($urandom); sm_en = 1'b1;
        @(negedge clk);
        sm_en = 1'b0;
        n = 0;
        while (sm_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("small_rand_dist_ns", int'(sm_dns), $countones(sm_q ^ sm_ns));
        chk("small_rand_dist_s",  int'(sm_ds),  $countones(sm_q ^ sm_s));
        chk("small_rand_label",   int'(sm_label),
            int'($countones(sm_q ^ sm_s) < $countones(sm_q ^ sm_ns)));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
